// File: rtl/cdda_stream.sv
// ============================================================================
//  Module      : cdda_stream
//  Description : CD-DA stereo playback buffer. Pairs of 16-bit words from the
//                sector transfer path (left then right) are packed into
//                frames and held in a block-RAM FIFO. Frames are replayed at
//                SAMPLE_RATE, generated from CLK by a fractional accumulator.
//                Provides flush, pause, overflow/underrun status, a fill
//                level and a sector-sized data request.
//  Options     : define CDDA_VOLUME_EN to enable per-channel volume scaling
//                (VOL_L/VOL_R). Without it the volume inputs are ignored.
//  Ports       : CLK, nRESET (sync, active-low)
//                WRITE_REQ  - at least one sector of free space
//                WRITE, DIN - word strobe (rising edge) and sample word
//                FLUSH      - clear FIFO and word phase
//                PAUSE      - output silence without consuming
//                VOL_L/R    - 8-bit channel volume (optional feature)
//                LEVEL      - frames buffered
//                OVERFLOW   - sticky frame-dropped flag
//                UNDERRUN   - pulse with AUDIO_CE when a tick found no data
//                AUDIO_CE, AUDIO_L, AUDIO_R - sample strobe and samples
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdda_stream #(
   parameter int CLK_RATE      = 30000000,
   parameter int SAMPLE_RATE   = 44100,
   parameter int SAMPLE_WIDTH  = 16,
   parameter int SECTOR_FRAMES = 588,
   parameter int DEPTH_SECTORS = 2,
   localparam int AW           = $clog2(DEPTH_SECTORS * SECTOR_FRAMES)
) (
   input  logic                    CLK,
   input  logic                    nRESET,
   output logic                    WRITE_REQ,
   input  logic                    WRITE,
   input  logic [SAMPLE_WIDTH-1:0] DIN,
   input  logic                    FLUSH,
   input  logic                    PAUSE,
   input  logic [7:0]              VOL_L,
   input  logic [7:0]              VOL_R,
   output logic [AW:0]             LEVEL,
   output logic                    OVERFLOW,
   output logic                    UNDERRUN,
   output logic                    AUDIO_CE,
   output logic [SAMPLE_WIDTH-1:0] AUDIO_L,
   output logic [SAMPLE_WIDTH-1:0] AUDIO_R
);

   localparam int          SW            = SAMPLE_WIDTH;
   localparam int          DEPTH         = 1 << AW;
   localparam logic [AW:0] FULL_LEVEL    = (AW+1)'(DEPTH - 1);
   // Largest fill level that still leaves room for a whole sector.
   localparam logic [AW:0] REQ_MAX_LEVEL = (AW+1)'(DEPTH - 1 - SECTOR_FRAMES);

   // ---------------------------------------------------------------- state
   logic [31:0]   acc_q,       acc_d;
   logic          tick_q,      tick_d;
   logic          write_q,     write_d;
   logic          phase_q,     phase_d;     // 0: expecting left word
   logic [SW-1:0] left_q,      left_d;
   logic [AW-1:0] wr_ptr_q,    wr_ptr_d;
   logic [AW-1:0] rd_ptr_q,    rd_ptr_d;
   logic [AW:0]   level_q,     level_d;
   logic          overflow_q,  overflow_d;
   logic          write_req_q, write_req_d;
   logic          s1_ce_q,     s1_ce_d;
   logic          s1_play_q,   s1_play_d;
   logic          s1_under_q,  s1_under_d;
   logic          audio_ce_q,  audio_ce_d;
   logic          underrun_q,  underrun_d;
   logic [SW-1:0] audio_l_q,   audio_l_d;
   logic [SW-1:0] audio_r_q,   audio_r_d;

   logic [2*SW-1:0] mem [DEPTH];
   logic [2*SW-1:0] rd_data_q;

   logic [32:0]   acc_sum;
   logic          commit;
   logic          commit_ok;
   logic          consume;
   logic [SW-1:0] vol_l;
   logic [SW-1:0] vol_r;

   // ------------------------------------------------------- volume scaling
`ifdef CDDA_VOLUME_EN
   function automatic logic [SW-1:0] apply_vol(input logic [SW-1:0] s,
                                                input logic [7:0]    v);
      logic signed [SW+8:0] p;
      p = $signed(s) * $signed({1'b0, v});
      // Full scale is treated as exact unity rather than 255/256.
      return (v == 8'hFF) ? s : p[SW+7:8];
   endfunction

   assign vol_l = apply_vol(rd_data_q[SW-1:0], VOL_L);
   assign vol_r = apply_vol(rd_data_q[2*SW-1:SW], VOL_R);
`else
   logic unused_vol;
   assign unused_vol = ^{VOL_L, VOL_R};
   assign vol_l      = rd_data_q[SW-1:0];
   assign vol_r      = rd_data_q[2*SW-1:SW];
`endif

   // ------------------------------------------------------ next-state logic
   always_comb begin
      // Fractional divider: one tick per CLK_RATE/SAMPLE_RATE cycles on average.
      acc_sum = {1'b0, acc_q} + 33'(SAMPLE_RATE);
      tick_d  = (acc_sum >= 33'(CLK_RATE));
      acc_d   = tick_d ? 32'(acc_sum - 33'(CLK_RATE)) : acc_sum[31:0];

      write_d    = WRITE;
      phase_d    = phase_q;
      left_d     = left_q;
      commit     = 1'b0;
      overflow_d = overflow_q;

      if (WRITE && !write_q) begin
         phase_d = ~phase_q;
         if (!phase_q) left_d = DIN;
         else          commit = 1'b1;
      end

      commit_ok = commit && (level_q != FULL_LEVEL) && !FLUSH;
      if (commit && (level_q == FULL_LEVEL)) overflow_d = 1'b1;

      // A flushing cycle is treated as empty so nothing stale is replayed.
      consume    = tick_q && !PAUSE && (level_q != '0) && !FLUSH;
      s1_ce_d    = tick_q;
      s1_play_d  = consume;
      s1_under_d = tick_q && !PAUSE && !consume;

      wr_ptr_d = wr_ptr_q + AW'(commit_ok);
      rd_ptr_d = rd_ptr_q + AW'(consume);

      case ({commit_ok, consume})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase

      write_req_d = (level_q <= REQ_MAX_LEVEL);

      audio_ce_d = s1_ce_q;
      underrun_d = s1_ce_q && s1_under_q;
      audio_l_d  = audio_l_q;
      audio_r_d  = audio_r_q;
      if (s1_ce_q) begin
         audio_l_d = s1_play_q ? vol_l : '0;
         audio_r_d = s1_play_q ? vol_r : '0;
      end

      if (FLUSH) begin
         phase_d    = 1'b0;
         level_d    = '0;
         overflow_d = 1'b0;
         wr_ptr_d   = wr_ptr_q;
         rd_ptr_d   = wr_ptr_q;
      end
   end

   // -------------------------------------------------------------- registers
   always_ff @(posedge CLK) begin
      if (!nRESET) begin
         acc_q       <= '0;
         tick_q      <= 1'b0;
         write_q     <= 1'b0;
         phase_q     <= 1'b0;
         left_q      <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         overflow_q  <= 1'b0;
         write_req_q <= 1'b0;
         s1_ce_q     <= 1'b0;
         s1_play_q   <= 1'b0;
         s1_under_q  <= 1'b0;
         audio_ce_q  <= 1'b0;
         underrun_q  <= 1'b0;
         audio_l_q   <= '0;
         audio_r_q   <= '0;
      end else begin
         acc_q       <= acc_d;
         tick_q      <= tick_d;
         write_q     <= write_d;
         phase_q     <= phase_d;
         left_q      <= left_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         overflow_q  <= overflow_d;
         write_req_q <= write_req_d;
         s1_ce_q     <= s1_ce_d;
         s1_play_q   <= s1_play_d;
         s1_under_q  <= s1_under_d;
         audio_ce_q  <= audio_ce_d;
         underrun_q  <= underrun_d;
         audio_l_q   <= audio_l_d;
         audio_r_q   <= audio_r_d;
      end
   end

   // Frame RAM. A frame is only consumed once LEVEL counts it, which is one
   // edge after its write, so the read port never hits the cell being written.
   always_ff @(posedge CLK) begin
      if (commit_ok) mem[wr_ptr_q] <= {DIN, left_q};
      rd_data_q <= mem[rd_ptr_q];
   end

   assign WRITE_REQ = write_req_q;
   assign LEVEL     = level_q;
   assign OVERFLOW  = overflow_q;
   assign UNDERRUN  = underrun_q;
   assign AUDIO_CE  = audio_ce_q;
   assign AUDIO_L   = audio_l_q;
   assign AUDIO_R   = audio_r_q;

endmodule

`default_nettype wire

// File: tb/tb_cdda_stream.sv
// ============================================================================
//  Module      : tb_cdda_stream
//  Description : Self-checking bench for cdda_stream. A frame queue plus the
//                closed-form tick schedule predict every sample strobe,
//                sample value, underrun and fill level. Honours
//                CDDA_VOLUME_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cdda_stream;

   localparam int  CR        = 1000000;
   localparam int  SR        = 44100;
   localparam int  SF        = 588;
   localparam int  CAP       = 2047;       // DEPTH-1 with DEPTH=2048
`ifdef CDDA_VOLUME_EN
   localparam bit  VOL_EN    = 1'b1;
`else
   localparam bit  VOL_EN    = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        nRESET = 1'b0;
   logic        WRITE_REQ;
   logic        WRITE = 1'b0;
   logic [15:0] DIN = '0;
   logic        FLUSH = 1'b0;
   logic        PAUSE = 1'b0;
   logic [7:0]  VOL_L = 8'h80;
   logic [7:0]  VOL_R = 8'hFF;
   logic [11:0] LEVEL;
   logic        OVERFLOW;
   logic        UNDERRUN;
   logic        AUDIO_CE;
   logic [15:0] AUDIO_L;
   logic [15:0] AUDIO_R;

   cdda_stream #(
      .CLK_RATE     (CR),
      .SAMPLE_RATE  (SR),
      .SAMPLE_WIDTH (16),
      .SECTOR_FRAMES(SF),
      .DEPTH_SECTORS(2)
   ) dut (
      .CLK      (CLK),
      .nRESET   (nRESET),
      .WRITE_REQ(WRITE_REQ),
      .WRITE    (WRITE),
      .DIN      (DIN),
      .FLUSH    (FLUSH),
      .PAUSE    (PAUSE),
      .VOL_L    (VOL_L),
      .VOL_R    (VOL_R),
      .LEVEL    (LEVEL),
      .OVERFLOW (OVERFLOW),
      .UNDERRUN (UNDERRUN),
      .AUDIO_CE (AUDIO_CE),
      .AUDIO_L  (AUDIO_L),
      .AUDIO_R  (AUDIO_R)
   );

   always #5 CLK = ~CLK;

   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   int          ce_cnt = 0;
   bit          mon_en = 1'b0;
   bit          pause_at [0:65535];
   logic [31:0] q [$];          // {right, left} frames the DUT should hold

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Tick count after k accumulations is floor(k*SR/CR); a tick is issued by
   // the k-th accumulation when that count steps.
   function automatic bit tick_at(input longint k);
      if (k < 1) return 1'b0;
      return ((k * SR) / CR) != (((k - 1) * SR) / CR);
   endfunction

   function automatic logic [15:0] vol_model(input logic [15:0] s, input logic [7:0] v);
      int p;
      if (!VOL_EN || v == 8'hFF) return s;
      p = int'($signed(s)) * int'(v);
      return 16'(p >>> 8);
   endfunction

   // Edge counter since reset release, and PAUSE as seen at each edge.
   always @(posedge CLK) begin
      if (!nRESET) cyc = 0;
      else begin
         cyc = cyc + 1;
         pause_at[cyc] = PAUSE;
      end
   end

   // Output monitor: a tick consumed at edge n-1 shows on AUDIO_CE after edge n.
   always @(negedge CLK) begin
      logic        exp_ce;
      logic [15:0] el, er;
      logic        eu;
      logic [31:0] f;
      if (nRESET && mon_en) begin
         exp_ce = tick_at(longint'(cyc) - 2);
         chk("audio_ce", AUDIO_CE, exp_ce);
         if (AUDIO_CE) ce_cnt++;
         if (exp_ce) begin
            if (pause_at[cyc-1]) begin
               el = '0; er = '0; eu = 1'b0;
            end else if (q.size() == 0) begin
               el = '0; er = '0; eu = 1'b1;
            end else begin
               f  = q.pop_front();
               el = vol_model(f[15:0], VOL_L);
               er = vol_model(f[31:16], VOL_R);
               eu = 1'b0;
            end
            chk("audio_l", AUDIO_L, el);
            chk("audio_r", AUDIO_R, er);
            chk("underrun", UNDERRUN, eu);
         end else begin
            chk("underrun_idle", UNDERRUN, 1'b0);
         end
      end
   end

   task automatic wr_word(input logic [15:0] w);
      @(negedge CLK);
      WRITE = 1'b1;
      DIN   = w;
      @(negedge CLK);
      WRITE = 1'b0;
   endtask

   task automatic wr_frame(input logic [15:0] l, input logic [15:0] r);
      wr_word(l);
      @(negedge CLK);
      WRITE = 1'b1;
      DIN   = r;
      if (q.size() < CAP) q.push_back({r, l});
      @(negedge CLK);
      WRITE = 1'b0;
   endtask

   task automatic do_flush();
      @(negedge CLK);
      FLUSH = 1'b1;
      q.delete();
      @(negedge CLK);
      FLUSH = 1'b0;
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge CLK);
      #1;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] a, b;
      bit          found;

      // ---------------------------------------------------------- reset
      repeat (4) @(negedge CLK);
      chk("rst_write_req", WRITE_REQ, 1'b0);
      chk("rst_level", LEVEL, 12'd0);
      chk("rst_overflow", OVERFLOW, 1'b0);
      chk("rst_underrun", UNDERRUN, 1'b0);
      chk("rst_audio_ce", AUDIO_CE, 1'b0);
      chk("rst_audio", {AUDIO_L, AUDIO_R}, 32'd0);
      nRESET = 1'b1;
      @(negedge CLK);
      mon_en = 1'b1;
      @(negedge CLK);
      #1 chk("write_req_after_reset", WRITE_REQ, 1'b1);

      // ----------------------------------------------- idle, underruns
      settle(3000);
      chk("ce_count", ce_cnt, 32'((longint'(cyc - 2) * SR) / CR));
      chk("idle_level", LEVEL, 12'd0);

      // ------------------------------------------------ four fixed words
      @(negedge CLK) PAUSE = 1'b1;
      wr_frame(16'h1111, 16'h2222);
      wr_frame(16'h3333, 16'h4444);
      settle(2);
      chk("level_two", LEVEL, 12'd2);
      @(negedge CLK) PAUSE = 1'b0;
      settle(120);
      chk("drained_level", LEVEL, 12'd0);

      // --------------------------------------- pause with ten buffered
      @(negedge CLK) PAUSE = 1'b1;
      wr_frame(16'h8000, 16'h7FFF);
      for (int i = 0; i < 9; i++) wr_frame(16'($urandom), 16'($urandom));
      settle(150);
      chk("paused_level", LEVEL, 12'd10);
      chk("paused_model", LEVEL, 12'(q.size()));
      @(negedge CLK) PAUSE = 1'b0;
      settle(300);
      chk("resume_level", LEVEL, 12'd0);

      // ------------------------- commit coinciding with a consuming tick
      @(negedge CLK) PAUSE = 1'b1;
      for (int i = 0; i < 5; i++) wr_frame(16'($urandom), 16'($urandom));
      a = 16'($urandom);
      b = 16'($urandom);
      wr_word(a);
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge CLK);
         if (tick_at(cyc)) found = 1'b1;
      end
      chk("tick_found", found, 1'b1);
      PAUSE = 1'b0;
      WRITE = 1'b1;
      DIN   = b;
      q.push_back({b, a});
      @(negedge CLK);
      PAUSE = 1'b1;
      WRITE = 1'b0;
      #1 chk("coincide_level", LEVEL, 12'd5);
      settle(3);
      chk("coincide_level_hold", LEVEL, 12'd5);
      chk("coincide_model", LEVEL, 12'(q.size()));

      // ------------------------------------------ flush resets phase
      wr_word(16'($urandom));
      do_flush();
      settle(1);
      chk("flush_level", LEVEL, 12'd0);
      a = 16'($urandom);
      b = 16'($urandom);
      wr_frame(a, b);
      settle(2);
      chk("after_flush_level", LEVEL, 12'd1);
      @(negedge CLK) PAUSE = 1'b0;
      settle(100);
      chk("flush_drain_level", LEVEL, 12'd0);

      // --------------------------------- fill to capacity and overflow
      @(negedge CLK) PAUSE = 1'b1;
      for (int i = 1; i <= CAP + 1; i++) begin
         wr_frame(16'($urandom), 16'($urandom));
         if (i == CAP - SF) begin
            settle(2);
            chk("write_req_last_sector", WRITE_REQ, 1'b1);
         end
         if (i == CAP - SF + 1) begin
            settle(2);
            chk("write_req_fall", WRITE_REQ, 1'b0);
         end
         if (i == CAP) begin
            settle(2);
            chk("full_no_overflow", OVERFLOW, 1'b0);
         end
      end
      settle(2);
      chk("full_level", LEVEL, 12'd2047);
      chk("full_model", LEVEL, 12'(q.size()));
      chk("overflow_set", OVERFLOW, 1'b1);
      do_flush();
      settle(2);
      chk("flush_full_level", LEVEL, 12'd0);
      chk("flush_overflow", OVERFLOW, 1'b0);
      chk("flush_write_req", WRITE_REQ, 1'b1);
      @(negedge CLK) PAUSE = 1'b0;
      settle(60);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
